// File: rtl/backscatter_phase_mod.sv
// backscatter_phase_mod
//   Square-wave carrier generator for the tag RF switch with M-ary phase
//   modulation applied during a triggered frame. Symbols arrive on a
//   valid/ready stream through a 1-entry hold register and each one shifts
//   the carrier phase by sym * (P >> PHASE_BITS) cycles for SYM_LEN periods.
//
//   Optional build macro: DIFF_ENC_EN -- differential encoding; the applied
//   symbol is the running sum of received symbols (mod 2**PHASE_BITS).
//
// Ports
//   clock       PLL global clock
//   reset       synchronous, active-high
//   trigger     asynchronous frame start (rising edge, 2-FF synchronised)
//   frame_len   symbols per frame, sampled when a trigger is accepted
//   sym_data    symbol value
//   sym_valid   sym_data valid
//   sym_ready   hold register can take sym_data this cycle
//   switch_out  registered RF switch drive
//   rss_en      switch enable, tied high
//   busy        frame in progress (ALIGN or RUN)
//   frame_done  1-cycle pulse after the last symbol period
//   underrun    1-cycle pulse on a symbol boundary with no data held
module backscatter_phase_mod #(
  parameter int HALF_PERIOD = 4,
  parameter int PHASE_BITS  = 1,
  parameter int SYM_LEN     = 2,
  parameter int FRAME_LEN_W = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic [FRAME_LEN_W-1:0] frame_len,
  input  logic [PHASE_BITS-1:0]  sym_data,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  output logic                   switch_out,
  output logic                   rss_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun
);
  localparam int P    = 2 * HALF_PERIOD;
  localparam int PW   = (P > 1) ? $clog2(P) : 1;
  localparam int PW1  = PW + 1;
  localparam int STEP = P >> PHASE_BITS;
  localparam int SW   = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SYM_LEN - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          phase_cnt_q, phase_cnt_d;
  logic [SW-1:0]          per_cnt_q, per_cnt_d;
  logic [FRAME_LEN_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
  logic [PHASE_BITS-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [PHASE_BITS-1:0]  cur_sym_q, cur_sym_d;
  logic                   switch_out_q, switch_out_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sync1_q, sync2_q, sync2_dly_q;

  logic                   rise, wrap, boundary, frame_end, take;
  logic [PHASE_BITS-1:0]  sym_new, sym_now;
  logic [PW1-1:0]         off, sum;

  assign rss_en     = 1'b1;
  assign switch_out = switch_out_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE) & ~reset;
  assign sym_ready  = busy & ~hold_full_q;
  assign underrun   = boundary & ~hold_full_q & ~reset;

  always_comb begin
    rise      = sync2_q & ~sync2_dly_q;
    wrap      = (phase_cnt_q == P_LAST);
    boundary  = (state_q == RUN) && (phase_cnt_q == '0) && (per_cnt_q == '0);
    frame_end = (state_q == RUN) && wrap && (per_cnt_q == S_LAST) &&
                (sym_cnt_q == frame_len_q);
    take      = sym_valid & sym_ready;

`ifdef DIFF_ENC_EN
    // Underrun adds nothing, so the previous phase is held.
    sym_new = hold_full_q ? (cur_sym_q + hold_q) : cur_sym_q;
`else
    sym_new = hold_full_q ? hold_q : '0;
`endif
    // The symbol that owns the current phase_cnt slot: the new one on a
    // boundary, so switch_out shows it exactly one cycle later.
    sym_now = boundary ? sym_new : cur_sym_q;

    off = (state_q == RUN) ? PW1'(32'(sym_now) * STEP) : '0;
    sum = {1'b0, phase_cnt_q} + off;
    if (sum >= PW1'(P)) sum = sum - PW1'(P);
    switch_out_d = (sum < PW1'(HALF_PERIOD));

    phase_cnt_d  = wrap ? '0 : phase_cnt_q + PW'(1);
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    frame_len_d  = frame_len_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    cur_sym_d    = cur_sym_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise && (frame_len != '0)) begin
          state_d     = ALIGN;
          frame_len_d = frame_len;
          sym_cnt_d   = '0;
          per_cnt_d   = '0;
          cur_sym_d   = '0;
          hold_full_d = 1'b0;
        end
      end
      ALIGN: begin
        if (wrap) state_d = RUN;
      end
      RUN: begin
        if (wrap) per_cnt_d = (per_cnt_q == S_LAST) ? '0 : per_cnt_q + SW'(1);
        if (boundary) begin
          sym_cnt_d   = sym_cnt_q + FRAME_LEN_W'(1);
          cur_sym_d   = sym_now;
          hold_full_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // take only happens with the hold empty, so it never collides with the
    // boundary unload above.
    if (take) begin
      hold_d      = sym_data;
      hold_full_d = 1'b1;
    end

    // Last period complete: the final switch_out still uses cur_sym_q,
    // the registered symbol is cleared for IDLE.
    if (frame_end) begin
      state_d      = IDLE;
      cur_sym_d    = '0;
      per_cnt_d    = '0;
      hold_full_d  = 1'b0;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_cnt_q  <= '0;
      per_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      frame_len_q  <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cur_sym_q    <= '0;
      switch_out_q <= 1'b0;
      frame_done_q <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync2_dly_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      per_cnt_q    <= per_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      frame_len_q  <= frame_len_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cur_sym_q    <= cur_sym_d;
      switch_out_q <= switch_out_d;
      frame_done_q <= frame_done_d;
      sync1_q      <= trigger;
      sync2_q      <= sync1_q;
      sync2_dly_q  <= sync2_q;
    end
  end
endmodule

// File: tb/tb_backscatter_phase_mod.sv
module tb_backscatter_phase_mod;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [11:0] frame_len = '0;
  logic        sym_data = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_ready, switch_out, rss_en, busy, frame_done, underrun;

  logic        q_trigger = 1'b0;
  logic [1:0]  q_data = '0;
  logic        q_valid = 1'b0;
  logic        q_ready, q_switch, q_rss, q_busy, q_done, q_under;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [3:0] stream;
  int n_sym = 0;
  int idx = 0;
  logic [7:0] car = 8'b11110000;
  logic [7:0] qpat = 8'b11000011;

  always #5 clock = ~clock;

  backscatter_phase_mod #(.HALF_PERIOD(4), .PHASE_BITS(1), .SYM_LEN(2), .FRAME_LEN_W(12)) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .frame_len(frame_len),
    .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .switch_out(switch_out), .rss_en(rss_en), .busy(busy),
    .frame_done(frame_done), .underrun(underrun));

  backscatter_phase_mod #(.HALF_PERIOD(4), .PHASE_BITS(2), .SYM_LEN(2), .FRAME_LEN_W(12)) dut_q (
    .clock(clock), .reset(reset), .trigger(q_trigger), .frame_len(frame_len),
    .sym_data(q_data), .sym_valid(q_valid), .sym_ready(q_ready),
    .switch_out(q_switch), .rss_en(q_rss), .busy(q_busy),
    .frame_done(q_done), .underrun(q_under));

  // cyc = edges since reset release, so the DUT phase_cnt equals cyc % 8.
  task automatic tick();
    @(posedge clock);
    if (reset) cyc = 0; else cyc = cyc + 1;
    #1;
  endtask

  task automatic step();
    logic f, qf;
    f  = sym_valid & sym_ready;
    qf = q_valid & q_ready;
    tick();
    if (f) begin
      idx = idx + 1;
      if (idx < n_sym) sym_data = stream[idx]; else sym_valid = 1'b0;
    end
    if (qf) q_valid = 1'b0;
  endtask

  task automatic load_stream(input logic [3:0] s, input int n);
    stream = s; n_sym = n; idx = 0;
    sym_data = s[0];
    sym_valid = (n > 0);
  endtask

  // Raises the trigger right after an edge with phase 0; returns after edge
  // Et+3 (ALIGN entered), with busy as seen after Et+2.
  task automatic start_frame(input logic use_q, input int len, output logic b2);
    while (cyc % 8 != 0) step();
    frame_len = 12'(len);
    if (use_q) q_trigger = 1'b1; else trigger = 1'b1;
    step();
    step();
    b2 = use_q ? q_busy : busy;
    trigger = 1'b0; q_trigger = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic e;
    sym_valid = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    compared++; if (switch_out !== 1'b0) begin mismatched++; $display("FAIL reset_switch got=%b exp=0", switch_out); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
    compared++; if (sym_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got=%b exp=0", sym_ready); end
    compared++; if (frame_done !== 1'b0 || underrun !== 1'b0) begin mismatched++; $display("FAIL reset_pulses got=%b%b exp=00", frame_done, underrun); end
    compared++; if (rss_en !== 1'b1) begin mismatched++; $display("FAIL rss_en got=%b exp=1", rss_en); end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = car[7 - ((k - 1) % 8)];
      compared++; if (switch_out !== e) begin mismatched++; $display("FAIL idle_carrier k=%0d got=%b exp=%b", k, switch_out, e); end
      compared++; if (busy !== 1'b0 || sym_ready !== 1'b0) begin mismatched++; $display("FAIL idle_busy_ready k=%0d got=%b%b exp=00", k, busy, sym_ready); end
    end
    sym_valid = 1'b0;
  endtask

  task automatic test_frame();
    logic b2, e;
    logic [2:0] es;
`ifdef DIFF_ENC_EN
    es = 3'b110;
`else
    es = 3'b010;
`endif
    load_stream(4'b0010, 3);
    compared++; if (sym_ready !== 1'b0) begin mismatched++; $display("FAIL frame_idle_ready got=%b exp=0", sym_ready); end
    start_frame(1'b0, 3, b2);
    compared++; if (b2 !== 1'b0) begin mismatched++; $display("FAIL frame_busy_early got=%b exp=0", b2); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL frame_busy_rise got=%b exp=1", busy); end
    repeat (5) step();
    for (int j = 0; j <= 48; j++) begin
      if (j >= 1) begin
        e = car[7 - ((j - 1) % 8)] ^ es[(j - 1) / 16];
        compared++; if (switch_out !== e) begin mismatched++; $display("FAIL frame_switch j=%0d got=%b exp=%b", j, switch_out, e); end
      end
      compared++; if (underrun !== 1'b0) begin mismatched++; $display("FAIL frame_underrun j=%0d got=%b exp=0", j, underrun); end
      compared++; if (frame_done !== (j == 48)) begin mismatched++; $display("FAIL frame_done j=%0d got=%b exp=%b", j, frame_done, (j == 48)); end
      compared++; if (busy !== (j < 48)) begin mismatched++; $display("FAIL frame_busy j=%0d got=%b exp=%b", j, busy, (j < 48)); end
      step();
    end
  endtask

  task automatic test_qpsk();
    logic b2, e;
    q_data = 2'd1; q_valid = 1'b1;
    start_frame(1'b1, 1, b2);
    compared++; if (q_busy !== 1'b1) begin mismatched++; $display("FAIL qpsk_busy got=%b exp=1", q_busy); end
    repeat (5) step();
    for (int j = 0; j <= 16; j++) begin
      if (j >= 1) begin
        e = qpat[7 - ((j - 1) % 8)];
        compared++; if (q_switch !== e) begin mismatched++; $display("FAIL qpsk_switch j=%0d got=%b exp=%b", j, q_switch, e); end
      end
      compared++; if (q_under !== 1'b0) begin mismatched++; $display("FAIL qpsk_underrun j=%0d got=%b exp=0", j, q_under); end
      compared++; if (q_done !== (j == 16)) begin mismatched++; $display("FAIL qpsk_done j=%0d got=%b exp=%b", j, q_done, (j == 16)); end
      step();
    end
    q_valid = 1'b0;
  endtask

  task automatic test_underrun();
    logic b2, e;
    load_stream(4'b0000, 0);
    start_frame(1'b0, 2, b2);
    repeat (5) step();
    for (int j = 0; j <= 32; j++) begin
      if (j >= 1) begin
        e = car[7 - ((j - 1) % 8)];
        compared++; if (switch_out !== e) begin mismatched++; $display("FAIL under_switch j=%0d got=%b exp=%b", j, switch_out, e); end
      end
      compared++; if (underrun !== (j == 0 || j == 16)) begin mismatched++; $display("FAIL under_pulse j=%0d got=%b exp=%b", j, underrun, (j == 0 || j == 16)); end
      compared++; if (frame_done !== (j == 32)) begin mismatched++; $display("FAIL under_done j=%0d got=%b exp=%b", j, frame_done, (j == 32)); end
      step();
    end
  endtask

  task automatic test_diff();
    logic b2, e;
    logic [2:0] es;
`ifdef DIFF_ENC_EN
    es = 3'b001;
`else
    es = 3'b011;
`endif
    load_stream(4'b0011, 3);
    start_frame(1'b0, 3, b2);
    repeat (5) step();
    for (int j = 0; j <= 48; j++) begin
      if (j >= 1) begin
        e = car[7 - ((j - 1) % 8)] ^ es[(j - 1) / 16];
        compared++; if (switch_out !== e) begin mismatched++; $display("FAIL diff_switch j=%0d got=%b exp=%b", j, switch_out, e); end
      end
      compared++; if (frame_done !== (j == 48)) begin mismatched++; $display("FAIL diff_done j=%0d got=%b exp=%b", j, frame_done, (j == 48)); end
      step();
    end
  endtask

  task automatic test_reset_midframe();
    logic b2, e;
    load_stream(4'b1010, 4);
    start_frame(1'b0, 4, b2);
    repeat (5) step();
    repeat (20) step();
    reset = 1'b1;
    tick();
    compared++; if (switch_out !== 1'b0) begin mismatched++; $display("FAIL mid_reset_switch got=%b exp=0", switch_out); end
    compared++; if (busy !== 1'b0 || sym_ready !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy_ready got=%b%b exp=00", busy, sym_ready); end
    compared++; if (frame_done !== 1'b0 || underrun !== 1'b0) begin mismatched++; $display("FAIL mid_reset_pulses got=%b%b exp=00", frame_done, underrun); end
    reset = 1'b0;
    load_stream(4'b0000, 0);
    for (int k = 0; k < 50; k++) begin
      step();
      compared++; if (frame_done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL mid_after k=%0d done/busy got=%b%b exp=00", k, frame_done, busy); end
    end
    load_stream(4'b0001, 1);
    start_frame(1'b0, 1, b2);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_restart_busy got=%b exp=1", busy); end
    repeat (5) step();
    for (int j = 0; j <= 16; j++) begin
      if (j >= 1) begin
        e = ~car[7 - ((j - 1) % 8)];
        compared++; if (switch_out !== e) begin mismatched++; $display("FAIL mid_restart_switch j=%0d got=%b exp=%b", j, switch_out, e); end
      end
      compared++; if (frame_done !== (j == 16)) begin mismatched++; $display("FAIL mid_restart_done j=%0d got=%b exp=%b", j, frame_done, (j == 16)); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_qpsk();
    test_underrun();
    test_diff();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
